// File: rtl/stateful_alu_v2.sv
// ============================================================================
// stateful_alu_v2
// ----------------------------------------------------------------------------
// Action-stage ALU that executes one action per transaction. Stateless ops
// (arithmetic, compares, logic, select) finish in a single step. Stateful ops
// (load, store, loadd, accumulate, max) do an atomic read-modify-write on a
// tenant-isolated RAM and take three steps. Only one transaction is ever in
// flight, so a write always lands before the next action can read.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   action_in            action word, opcode in the top 8 bits
//   action_valid         action present; accepted when ready_out is high
//   operand_1_in         operand 1 / store data / accumulate value
//   operand_2_in         operand 2; low ADDR_WIDTH bits = RAM offset
//   operand_3_in         operand 3 / pass-through value
//   ready_out            block can accept an action
//   page_base, page_len  tenant region (base address, length in words)
//   page_valid           tenant page entry valid
//   container_out        result container
//   container_out_valid  result valid, held until ready_in
//   overflow_out         stateful access was rejected by isolation check
//   ready_in             downstream accepts result
// ============================================================================
module stateful_alu_v2 #(
   parameter int DATA_WIDTH = 32,
   parameter int ACTION_LEN = 64,
   parameter int ADDR_WIDTH = 8,
   parameter int RAM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ACTION_LEN-1:0] action_in,
   input  logic                  action_valid,
   input  logic [DATA_WIDTH-1:0] operand_1_in,
   input  logic [DATA_WIDTH-1:0] operand_2_in,
   input  logic [DATA_WIDTH-1:0] operand_3_in,
   output logic                  ready_out,
   input  logic [ADDR_WIDTH-1:0] page_base,
   input  logic [ADDR_WIDTH-1:0] page_len,
   input  logic                  page_valid,
   output logic [DATA_WIDTH-1:0] container_out,
   output logic                  container_out_valid,
   output logic                  overflow_out,
   input  logic                  ready_in
);

   localparam logic [7:0] OP_ADD   = 8'h01;
   localparam logic [7:0] OP_SUB   = 8'h02;
   localparam logic [7:0] OP_NEQ   = 8'h04;
   localparam logic [7:0] OP_EQ    = 8'h06;
   localparam logic [7:0] OP_LOADD = 8'h07;
   localparam logic [7:0] OP_STORE = 8'h08;
   localparam logic [7:0] OP_LOAD  = 8'h0B;
   localparam logic [7:0] OP_ACC   = 8'h0D;
   localparam logic [7:0] OP_SET   = 8'h0E;
   localparam logic [7:0] OP_MAX   = 8'h0F;
   localparam logic [7:0] OP_ITE   = 8'h10;
   localparam logic [7:0] OP_LOR   = 8'h12;
   localparam logic [7:0] OP_LAND  = 8'h13;
   localparam logic [7:0] OP_GEQ   = 8'h18;
   localparam logic [7:0] OP_LT    = 8'h1C;

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      EXEC = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [7:0]            opcode_q;
   logic [DATA_WIDTH-1:0] op1_q;
   logic [DATA_WIDTH-1:0] op3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  reject_q;

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] ram_rd_data;
   logic                  ram_re;
   logic                  ram_we;

   logic [DATA_WIDTH-1:0] exec_result;
   logic [DATA_WIDTH-1:0] exec_wdata;
   logic                  exec_wen;

   function automatic logic [DATA_WIDTH-1:0] bool_ext(input logic b);
      return {{(DATA_WIDTH-1){1'b0}}, b};
   endfunction

   function automatic logic op_is_stateful(input logic [7:0] op);
      logic s;
      case (op)
         OP_LOAD, OP_STORE, OP_LOADD, OP_ACC, OP_MAX: s = 1'b1;
         default:                                     s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] stateless_result(
      input logic [7:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [DATA_WIDTH-1:0] c
   );
      logic [DATA_WIDTH-1:0] r;
      r = c;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_SET:  r = b;
         OP_EQ:   r = bool_ext(a == b);
         OP_NEQ:  r = bool_ext(a != b);
         OP_GEQ:  r = bool_ext(a >= b);
         OP_LT:   r = bool_ext(a < b);
         OP_LAND: r = bool_ext((a != '0) && (b != '0));
         OP_LOR:  r = bool_ext((a != '0) || (b != '0));
         OP_ITE:  r = (a != '0) ? b : c;
         default: r = c;
      endcase
      return r;
   endfunction

   logic [7:0]            opcode_in;
   logic [ADDR_WIDTH-1:0] offset_in;
   logic                  reject_in;
   logic                  accept;
   logic                  unused_action_bits;

   assign opcode_in          = action_in[ACTION_LEN-1 -: 8];
   assign offset_in          = operand_2_in[ADDR_WIDTH-1:0];
   assign reject_in          = !page_valid || (offset_in >= page_len);
   assign accept             = action_valid && ready_out;
   assign ready_out          = (state_q == IDLE);
   assign unused_action_bits = ^action_in[ACTION_LEN-9:0];

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Stateless ops jump straight to OUT; stateful ops take the RAM read
   // and the read-modify-write step first. Rejected stateful ops still walk
   // the long path so latency depends only on the opcode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = op_is_stateful(opcode_in) ? RD : OUT;
            end
         end
         RD:      state_d = EXEC;
         EXEC:    state_d = OUT;
         OUT: begin
            if (ready_in) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Transaction context captured at acceptance. The isolation decision is
   // made here so page inputs need not stay stable afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q <= '0;
         op1_q    <= '0;
         op3_q    <= '0;
         addr_q   <= '0;
         reject_q <= 1'b0;
      end else if (accept) begin
         opcode_q <= opcode_in;
         op1_q    <= operand_1_in;
         op3_q    <= operand_3_in;
         addr_q   <= page_base + offset_in;
         reject_q <= reject_in;
      end
   end

   // Read-modify-write result for the EXEC step. A rejected access passes
   // operand 3 through and never writes.
   always_comb begin
      exec_result = op3_q;
      exec_wdata  = ram_rd_data;
      exec_wen    = 1'b0;
      if (!reject_q) begin
         case (opcode_q)
            OP_LOAD: begin
               exec_result = ram_rd_data;
            end
            OP_STORE: begin
               exec_wdata  = op1_q;
               exec_wen    = 1'b1;
               exec_result = op3_q;
            end
            OP_LOADD: begin
               exec_wdata  = ram_rd_data + ONE;
               exec_wen    = 1'b1;
               exec_result = ram_rd_data + ONE;
            end
            OP_ACC: begin
               exec_wdata  = ram_rd_data + op1_q;
               exec_wen    = 1'b1;
               exec_result = ram_rd_data + op1_q;
            end
            OP_MAX: begin
               exec_wdata  = (ram_rd_data > op1_q) ? ram_rd_data : op1_q;
               exec_wen    = 1'b1;
               exec_result = (ram_rd_data > op1_q) ? ram_rd_data : op1_q;
            end
            default: begin
               exec_result = op3_q;
            end
         endcase
      end
   end

   assign ram_re = (state_q == RD) && !reject_q;
   assign ram_we = (state_q == EXEC) && exec_wen;

   // Stateful RAM: synchronous read, write at the EXEC edge. Contents are
   // deliberately not reset.
   always_ff @(posedge clk) begin
      if (ram_re) begin
         ram_rd_data <= mem[addr_q];
      end
      if (ram_we) begin
         mem[addr_q] <= exec_wdata;
      end
   end

   // Output registers: loaded when entering OUT, then held untouched while
   // downstream stalls. Valid drops on the handshake edge; the container
   // keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         container_out       <= '0;
         container_out_valid <= 1'b0;
         overflow_out        <= 1'b0;
      end else if ((state_q == IDLE) && accept && !op_is_stateful(opcode_in)) begin
         container_out       <= stateless_result(opcode_in, operand_1_in,
                                                 operand_2_in, operand_3_in);
         container_out_valid <= 1'b1;
         overflow_out        <= 1'b0;
      end else if (state_q == EXEC) begin
         container_out       <= exec_result;
         container_out_valid <= 1'b1;
         overflow_out        <= reject_q;
      end else if ((state_q == OUT) && ready_in) begin
         container_out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/stateful_alu_v2.md
Name: stateful_alu_v2

Overview:
Parametrised successor to the single-container stateful ALU in the rmtv2 action stage. It executes one action per transaction against a tenant-isolated stateful RAM whose depth and data width are parameters. It adds atomic read-modify-write ops (accumulate, max), a per-transaction overflow indication, a proper valid/ready output hold, and variable latency: stateless ops finish faster than stateful ops. Its output feeds PHV container assembly.

Parameters:
DATA_WIDTH, 32, width of operands, container and RAM words
ACTION_LEN, 64, action word width; opcode is action_in[ACTION_LEN-1 -: 8]
ADDR_WIDTH, 8, stateful RAM address width
RAM_DEPTH, 256, RAM words; must equal 2**ADDR_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
action_in  in  ACTION_LEN  action word
action_valid  in  1  action present
operand_1_in  in  DATA_WIDTH  operand 1 / store data / accumulate value
operand_2_in  in  DATA_WIDTH  operand 2; bits [ADDR_WIDTH-1:0] = RAM offset for stateful ops
operand_3_in  in  DATA_WIDTH  operand 3 / pass-through value
ready_out  out  1  block can accept an action
page_base  in  ADDR_WIDTH  tenant base address
page_len  in  ADDR_WIDTH  tenant region length in words
page_valid  in  1  page entry valid; sampled with the action
container_out  out  DATA_WIDTH  result container
container_out_valid  out  1  result valid
overflow_out  out  1  qualifies container_out: stateful access was rejected
ready_in  in  1  downstream accepts result

Behaviour:
- Reset is asynchronous and active-low. Reset values: ready_out=1, container_out=0, container_out_valid=0, overflow_out=0, FSM=IDLE, no RAM write pending. RAM contents are not reset.
- Acceptance: an action is accepted on a rising edge where action_valid && ready_out. Operands, opcode and page info are registered at that edge. Only one transaction is in flight; ready_out=0 from acceptance until the output handshake completes.
- Stateless ops complete IDLE->OUT, so valid rises 1 cycle after acceptance:
  - 0x01 add: op1+op2.
  - 0x02 sub: op1-op2.
  - 0x0E set: op2.
  - 0x06 eq: op1==op2.
  - 0x04 neq: op1!=op2.
  - 0x18 geq: op1>=op2, unsigned.
  - 0x1C lt: op1<op2, unsigned.
  - 0x13 land, 0x12 lor: logical and/or of the operands.
  - 0x10 ite: op1!=0 ? op2 : op3.
  - Any unlisted opcode: op3.
  - Arithmetic wraps modulo 2**DATA_WIDTH. Boolean results are zero-extended 0/1.
- Stateful ops follow IDLE->RD->EXEC->OUT, so valid rises 3 cycles after acceptance:
  - 0x0B load: result=M.
  - 0x08 store: M<=op1, result=op3.
  - 0x07 loadd: M<=M+1, result=M+1.
  - 0x0D accumulate: M<=M+op1, result=M+op1.
  - 0x0F max: M<=max(M,op1) unsigned, result=new M.
- Addressing: offset = op2[ADDR_WIDTH-1:0]; physical address = (page_base+offset) mod RAM_DEPTH, wrapping allowed.
- Isolation: the access is rejected if offset >= page_len or page_valid=0. On rejection: no RAM read effect, no write, result=op3, overflow_out=1 with valid. page_len=0 rejects everything.
- RAM: synchronous read with 1-cycle latency (address in RD, data in EXEC); write happens at the EXEC edge.
- Read-after-write safety: the next action cannot be accepted before the prior write has completed, so no forwarding is needed.
- Output: in OUT, container_out, overflow_out and container_out_valid stay stable while ready_in=0. The handshake completes on an edge with container_out_valid && ready_in.
  - Same edge: valid drops, FSM goes to IDLE, ready_out rises.
  - The next action is accepted no earlier than the following edge.
- Reset mid-transaction aborts it. A write whose EXEC edge coincides with reset assertion is not guaranteed; any write completed before reset persists.

Test Plan:
- Reset, then add op1=0xFFFFFFFF, op2=2, ready_in=1 -> container_out=0x00000001, overflow_out=0, valid exactly 1 cycle after acceptance, ready_out back to 1.
- base=0x10, len=4: store op1=0xAB offset 3; then load offset 3 -> load returns 0xAB after 3 cycles; RAM[0x13]=0xAB.
- loadd ×3 at offset 0 (base=0xFE, RAM zeroed via stores) -> results 1, 2, 3; accumulate op1=5 -> 8; max op1=4 -> 8; max op1=20 -> 20.
- store offset 4 with len=4 -> result=op3, overflow_out=1, no write (a follow-up load at offset 3 is unchanged); same with page_valid=0.
- base=0xFF, offset 2, len=8: store 0x55 -> RAM[0x01]=0x55 (wrap-around).
- ready_in held 0 for 5 cycles during a loadd -> outputs stable, ready_out=0, an action_valid pulse is ignored; assert rst_n low mid-RD -> all outputs at reset values immediately.
